// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// master: the producer/consumer side that drives requests and watches status.
// slave:  the FIFO itself.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, wdata, rinc, flush, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, flush, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty, synchronous flush and sticky error flags.
// Optional feature macro: FIFO_FWFT_EN
//   defined   -> first-word fall-through, rdata shows the head entry.
//   undefined -> registered read data, one cycle read latency.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4
) (
    input logic            clk,
    input logic            nrst,
    sync_fifo_flex_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [AW:0] DEPTH_C = PW'(DEPTH);
    localparam logic [AW:0] AF_C    = PW'(AF_THRESH);
    localparam logic [AW:0] AE_C    = PW'(AE_THRESH);
    localparam logic [AW:0] ONE_C   = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [AW:0] count_q, count_n;
    logic        full_q, empty_q, af_q, ae_q;
    logic        full_n, empty_n, af_n, ae_n;
    logic        ovf_q, unf_q, ovf_n, unf_n;
    logic        wr_acc, rd_acc;

    // Acceptance decisions and next pointer/flag values from start-of-cycle flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        wr_acc   = 1'b0;
        rd_acc   = 1'b0;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        ovf_n    = ovf_q & ~bus.clr_err;
        unf_n    = unf_q & ~bus.clr_err;

        if (bus.flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            wr_acc = bus.winc & ~full_q;
            rd_acc = bus.rinc & ~empty_q;
            if (wr_acc) wr_ptr_n = wr_ptr + ONE_C;
            if (rd_acc) rd_ptr_n = rd_ptr + ONE_C;
            // A new error in the same cycle as clr_err wins.
            if (bus.winc && full_q)  ovf_n = 1'b1;
            if (bus.rinc && empty_q) unf_n = 1'b1;
        end

        // Pointer difference modulo 2*DEPTH is the occupancy 0..DEPTH.
        count_n = wr_ptr_n - rd_ptr_n;
        full_n  = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                  (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
        empty_n = (wr_ptr_n == rd_ptr_n);
        af_n    = (count_n >= AF_C);
        ae_n    = (count_n <= AE_C);
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!nrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count_q <= count_n;
            full_q  <= full_n;
            empty_q <= empty_n;
            af_q    <= af_n;
            ae_q    <= ae_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; pointers alone define valid contents.
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.wdata;
    end

`ifdef FIFO_FWFT_EN
    // Head entry is shown combinationally whenever the FIFO holds data.
    always_comb begin
        bus.rdata  = empty_q ? '0 : mem[rd_ptr[AW-1:0]];
        bus.rvalid = ~empty_q;
    end
`else
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // Registered read port: load on an accepted pop, pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    // Depth fits in the count width by construction; keeps the constant referenced.
    logic unused_depth;
    assign unused_depth = ^DEPTH_C;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex (DATA_WIDTH=8, DEPTH=8, AF=6, AE=2).
// A queue-based reference model tracks contents, sticky flags and read data.
module tb_sync_fifo_flex;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_flex #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q [$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;

    typedef struct {
        int w; int d; int r; int f; int c;
        int cnt; int full; int empty; int af; int ae; int ovf; int unf;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] e_rd;
        logic          e_rv;
        int            n;
        n = q.size();
`ifdef FIFO_FWFT_EN
        e_rd = (n > 0) ? q[0] : '0;
        e_rv = (n > 0);
`else
        e_rd = m_rdata;
        e_rv = m_rvalid;
`endif
        check("count",        32'(bus.count),        32'(n));
        check("full",         32'(bus.full),         32'(n == DEPTH));
        check("empty",        32'(bus.empty),        32'(n == 0));
        check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
        check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        check("overflow",     32'(bus.overflow),     32'(m_ovf));
        check("underflow",    32'(bus.underflow),    32'(m_unf));
        check("rdata",        32'(bus.rdata),        32'(e_rd));
        check("rvalid",       32'(bus.rvalid),       32'(e_rv));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare everything.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic c);
        int n;
        bus.winc = w; bus.wdata = d; bus.rinc = r; bus.flush = f; bus.clr_err = c;
        @(posedge clk);
        #1;
        n = q.size();
        m_rvalid = 1'b0;
        m_ovf = m_ovf & ~c;
        m_unf = m_unf & ~c;
        if (f) begin
            q.delete();
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0)     m_unf = 1'b1;
            if (r && n > 0) begin
                m_rdata  = q.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && n < DEPTH) q.push_back(d);
        end
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        nrst = 1'b0;
        #2;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        compare_all();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        // Hand-derived cycle table starting from an empty FIFO.
        vt[0]  = '{1, 8'h01, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0};
        vt[1]  = '{1, 8'h02, 0, 0, 0,   2, 0, 0, 0, 1, 0, 0};
        vt[2]  = '{1, 8'h03, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{1, 8'h04, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{1, 8'h05, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0};
        vt[5]  = '{1, 8'h06, 0, 0, 0,   6, 0, 0, 1, 0, 0, 0};
        vt[6]  = '{1, 8'h07, 0, 0, 0,   7, 0, 0, 1, 0, 0, 0};
        vt[7]  = '{1, 8'h08, 0, 0, 0,   8, 1, 0, 1, 0, 0, 0};
        vt[8]  = '{1, 8'h09, 0, 0, 0,   8, 1, 0, 1, 0, 1, 0};
        vt[9]  = '{0, 8'h00, 0, 0, 1,   8, 1, 0, 1, 0, 0, 0};
        vt[10] = '{1, 8'hAA, 1, 0, 0,   7, 0, 0, 1, 0, 1, 0};
        vt[11] = '{1, 8'hBB, 0, 1, 0,   0, 0, 1, 0, 1, 1, 0};
        vt[12] = '{0, 8'h00, 1, 0, 0,   0, 0, 1, 0, 1, 1, 1};
        vt[13] = '{1, 8'hCC, 1, 0, 1,   1, 0, 0, 0, 1, 0, 1};
        vt[14] = '{0, 8'h00, 0, 0, 1,   1, 0, 0, 0, 1, 0, 0};
        vt[15] = '{0, 8'h00, 1, 0, 0,   0, 0, 1, 0, 1, 0, 0};

        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Reset while words are stored.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.count), 32'd3);
        bus.winc = 1'b1;
        do_reset();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_ae",    32'(bus.almost_empty), 32'd1);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);

        // Table-driven sequence.
        for (int i = 0; i < 16; i++) begin
            step(1'(vt[i].w), DW'(vt[i].d), 1'(vt[i].r), 1'(vt[i].f), 1'(vt[i].c));
            check($sformatf("tbl%0d_count", i), 32'(bus.count),        32'(vt[i].cnt));
            check($sformatf("tbl%0d_full", i),  32'(bus.full),         32'(vt[i].full));
            check($sformatf("tbl%0d_empty", i), 32'(bus.empty),        32'(vt[i].empty));
            check($sformatf("tbl%0d_af", i),    32'(bus.almost_full),  32'(vt[i].af));
            check($sformatf("tbl%0d_ae", i),    32'(bus.almost_empty), 32'(vt[i].ae));
            check($sformatf("tbl%0d_ovf", i),   32'(bus.overflow),     32'(vt[i].ovf));
            check($sformatf("tbl%0d_unf", i),   32'(bus.underflow),    32'(vt[i].unf));
        end

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        check("fill_ovf",   32'(bus.overflow), 32'd1);
        check("fill_count", 32'(bus.count),    32'd8);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            check($sformatf("drain%0d", i), 32'(bus.rdata), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
`else
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check($sformatf("drain%0d", i), 32'(bus.rdata), 32'(i));
`endif
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow then clear.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("unf_set",   32'(bus.underflow), 32'd1);
        check("unf_count", 32'(bus.count),     32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("unf_clr",   32'(bus.underflow), 32'd0);

        // Steady-state streaming at count=4 across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(8'h14 + i), 1'b1, 1'b0, 1'b0);
            check($sformatf("stream%0d_count", i), 32'(bus.count), 32'd4);
`ifndef FIFO_FWFT_EN
            check($sformatf("stream%0d_data", i), 32'(bus.rdata), 32'(8'h10 + i));
`endif
        end
        check("stream_ovf", 32'(bus.overflow),  32'd0);
        check("stream_unf", 32'(bus.underflow), 32'd0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush overrides a same-cycle write.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check("flush_count",  32'(bus.count),  32'd0);
        check("flush_empty",  32'(bus.empty),  32'd1);
        check("flush_rvalid", 32'(bus.rvalid), 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_flush_count", 32'(bus.count), 32'd0);

        // Read latency.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("lat_fwft_rdata",  32'(bus.rdata),  32'hA5);
        check("lat_fwft_rvalid", 32'(bus.rvalid), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_fwft_pop_rvalid", 32'(bus.rvalid), 32'd0);
        check("lat_fwft_pop_rdata",  32'(bus.rdata),  32'd0);
`else
        check("lat_pre_rvalid", 32'(bus.rvalid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_rdata",  32'(bus.rdata),  32'hA5);
        check("lat_rvalid", 32'(bus.rvalid), 32'd1);
        idle();
        check("lat_hold_rdata", 32'(bus.rdata),  32'hA5);
        check("lat_pulse_end",  32'(bus.rvalid), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 55, DW'($urandom),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 6);
            if (i == 300) do_reset();
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
